// File: rtl/sdpb_ram_pkg.sv
// Shared types and the byte-merge helper for the sdpb_ram block RAM model.
// The merge helper works on a maximum-width word; callers size-cast in and out.
package sdpb_pkg;

  typedef enum logic {
    RD_BYPASS   = 1'b0,
    RD_PIPELINE = 1'b1
  } read_mode_e;

  typedef enum logic {
    WR_READ_FIRST    = 1'b0,
    WR_WRITE_THROUGH = 1'b1
  } write_mode_e;

  localparam int MAX_DW = 1024;
  localparam int MAX_BW = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] be_merge(
    input logic [MAX_DW-1:0] old_word,
    input logic [MAX_DW-1:0] new_word,
    input logic [MAX_BW-1:0] be
  );
    logic [MAX_DW-1:0] merged;
    for (int i = 0; i < MAX_BW; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sdpb_ram_outreg.sv
// OCE-gated stage-2 output register with its valid flag (pipeline read mode).
module sdpb_outreg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             oce,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;

  // Load stage 1 on an enabled edge; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= RESET_VAL;
      q_valid_r <= 1'b0;
    end else if (oce) begin
      q_r       <= d;
      q_valid_r <= d_valid;
    end
  end

  assign q       = q_r;
  assign q_valid = q_valid_r;

endmodule

// File: rtl/sdpb_ram.sv
// Single-clock simple-dual-port block RAM: byte-enabled write port A, read port B,
// bypass or OCE-gated pipelined output, and selectable read-during-write behaviour.
module sdpb_ram
  import sdpb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic                  READ_MODE  = 1'b0,
  parameter logic                  WRITE_MODE = 1'b0,
  parameter logic [2:0]            BLK_SEL_A  = 3'b000,
  parameter logic [2:0]            BLK_SEL_B  = 3'b000,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    CEA,
  input  logic [ADDR_WIDTH-1:0]   ADA,
  input  logic [DATA_WIDTH-1:0]   DI,
  input  logic [DATA_WIDTH/8-1:0] BEA,
  input  logic [2:0]              BLKSELA,
  input  logic                    CEB,
  input  logic [ADDR_WIDTH-1:0]   ADB,
  input  logic [2:0]              BLKSELB,
  input  logic                    OCE,
  output logic [DATA_WIDTH-1:0]   DO,
  output logic                    DO_VALID
);

  localparam int          DEPTH = 2 ** ADDR_WIDTH;
  localparam read_mode_e  RMODE = read_mode_e'(READ_MODE);
  localparam write_mode_e WMODE = write_mode_e'(WRITE_MODE);
  // In bypass mode R1 drives DO directly, so it must come out of reset as RESET_VAL.
  localparam logic [DATA_WIDTH-1:0] R1_RST =
    (RMODE == RD_BYPASS) ? RESET_VAL : {DATA_WIDTH{1'b0}};

  if (((DATA_WIDTH % 8) != 0) || (DATA_WIDTH > MAX_DW)) begin : g_bad_width
    $error("sdpb_ram: DATA_WIDTH must be a multiple of 8 and at most %0d", MAX_DW);
  end

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  collide_s;
  logic [DATA_WIDTH-1:0] wr_word_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] r1_r;
  logic                  v1_r;

  // Port enables, merged write word and the collision-resolved read word.
  always_comb begin
    wr_en_s   = RESETN && CEA && (BLKSELA == BLK_SEL_A);
    rd_en_s   = RESETN && CEB && (BLKSELB == BLK_SEL_B);
    collide_s = wr_en_s && rd_en_s && (ADA == ADB);
    wr_word_s = DATA_WIDTH'(be_merge(MAX_DW'(mem_r[ADA]), MAX_DW'(DI), MAX_BW'(BEA)));
    if (collide_s && (WMODE == WR_WRITE_THROUGH)) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_r[ADB];
    end
  end

  // Array write; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[ADA] <= wr_word_s;
    end
  end

  // Stage-1 read register; holds between reads.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r1_r <= R1_RST;
      v1_r <= 1'b0;
    end else if (rd_en_s) begin
      r1_r <= rd_word_s;
      v1_r <= 1'b1;
    end
  end

  if (RMODE == RD_PIPELINE) begin : g_pipe
    sdpb_outreg #(
      .WIDTH     (DATA_WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_outreg (
      .clk     (CLK),
      .rst_n   (RESETN),
      .oce     (OCE),
      .d       (r1_r),
      .d_valid (v1_r),
      .q       (DO),
      .q_valid (DO_VALID)
    );
  end else begin : g_bypass
    logic unused_oce_s;
    assign unused_oce_s = OCE;
    assign DO           = r1_r;
    assign DO_VALID     = v1_r;
  end

endmodule
